spart_rx_fifo: RTL
==================

// Module: spart_rx_fifo
// PURPOSE
//  Parametrised SPART receive channel: 16x-oversampled async serial receiver with run-time
//  programmable baud divisor, DATA_W-bit frames and a DEPTH-entry receive FIFO with sticky
//  error flags. Sits between the GPIO RX pin and the bus/driver logic in the Minilab3 top level.
//  Successor to the fixed-width, unbuffered receive path.
// PARAMETERS
//  DATA_W   8     data bits per frame (5..9), LSB first
//  DEPTH    8     FIFO entries; power of 2, >=2
//  DIV_W    16    baud divisor width
//  DIV_RST  650   divisor after reset; tick every DIV+1 clks (50 MHz/(651*16) ~= 4800 bps)
// PORTS
//  clk       in   1       system clock (CLOCK_50 domain)
//  rst_n     in   1       asynchronous active-low reset
//  rxd       in   1       serial input, idle high, asynchronous to clk
//  div_wr    in   1       load div_din into baud divisor
//  div_din   in   DIV_W   new divisor value
//  rd_en     in   1       pop FIFO head
//  rd_data   out  DATA_W  FIFO head (first-word fall-through)
//  rx_valid  out  1       FIFO non-empty
//  fifo_full out  1       FIFO holds DEPTH entries
//  busy      out  1       FSM not in IDLE
//  overrun   out  1       sticky: good frame arrived while FIFO full
//  frame_err out  1       sticky: stop bit sampled 0
//  par_err   out  1       sticky: parity mismatch (const 0 without macro)
//  err_clr   in   1       clears all sticky flags
// BEHAVIOUR
//  - Reset: all outputs 0, FIFO empty, rd_data 0, divisor=DIV_RST, FSM IDLE, sync flops=1.
//  - rxd passes a 2-FF synchronizer (2 clk latency); prev-sample flop for edge detect.
//  - Baud gen: down-counter reloads DIV on 0 and emits 1-clk tick; div_wr reloads counter
//    with div_din, aborts any frame (-> IDLE, byte dropped, no flag); DIV=0 => tick every clk.
//  - FSM (cnt = 4-bit tick counter, bitn = bit index):
//    IDLE: synced falling edge (prev=1,cur=0) -> START, cnt=0. Line held low never retriggers.
//    START: at cnt=7 (mid-bit) rxd=0 -> DATA, cnt=0; rxd=1 -> IDLE (glitch reject).
//    DATA: every 16th tick sample into shift reg LSB first; after DATA_W bits -> STOP.
//    STOP: at 16th tick: rxd=1 -> push (or set overrun, drop, if full and no rd_en same clk);
//          rxd=0 -> frame_err=1, drop. Both -> IDLE.
//  - Push visible: rx_valid=1, rd_data=byte on clk after the stop-bit sample.
//  - rd_en with FIFO empty ignored. Push+pop same clk: both happen, count unchanged, no
//    overrun even if full. Pointers wrap mod DEPTH; count DIV by log2(DEPTH)+1 bits.
//  - err_clr and a new error same clk: error wins (flag stays 1).
//  - rst_n asserted mid-frame: immediate return to reset state; partial frame discarded.
// CONFIGURATION
//  SPART_PARITY_EN defined: frame = start, DATA_W data, even parity bit, stop; PARITY state
//   between DATA and STOP samples at 16th tick; mismatch sets par_err, byte dropped at STOP.
//  Undefined: no PARITY state, DATA -> STOP directly, par_err tied 0.
// TESTING
//  1 rst_n low mid-frame (DIV=3) -> all outputs 0, busy 0, FIFO empty; divisor back to 650.
//  2 div_wr DIV=3 (64 clk/bit), send 0xA5 -> rx_valid=1, rd_data=0xA5; rd_en -> rx_valid=0.
//  3 DIV=3, rxd low 10 clk then high -> no push, busy back to 0, no error flags.
//  4 send 0x3C with stop bit 0 -> frame_err=1, FIFO empty; err_clr -> frame_err=0.
//  5 send 0x00..0x08 (9 frames) no reads -> fifo_full after 8th, overrun=1; 8 reads
//    return 0x00..0x07, then rx_valid=0.
//  6 SPART_PARITY_EN: 0x01 with parity 0 -> par_err=1, no push; parity 1 -> push 0x01.

Source files
------------

// File: rtl/spart_rx_fifo.sv
// SPART receive channel: 16x-oversampled serial receiver with programmable baud divisor
// feeding a first-word fall-through FIFO with sticky error flags. Optional macro: SPART_PARITY_EN.
module spart_rx_fifo #(
  parameter int DATA_W  = 8,
  parameter int DEPTH   = 8,
  parameter int DIV_W   = 16,
  parameter int DIV_RST = 650
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              rxd,
  input  logic              div_wr,
  input  logic [DIV_W-1:0]  div_din,
  input  logic              rd_en,
  output logic [DATA_W-1:0] rd_data,
  output logic              rx_valid,
  output logic              fifo_full,
  output logic              busy,
  output logic              overrun,
  output logic              frame_err,
  output logic              par_err,
  input  logic              err_clr
);

  localparam int PTR_W = $clog2(DEPTH);
  localparam int CNT_W = $clog2(DEPTH) + 1;
  localparam int BIT_W = $clog2(DATA_W + 1);
  localparam logic [DIV_W-1:0] DIV_RST_V = DIV_W'(DIV_RST);
  localparam logic [BIT_W-1:0] LAST_BIT  = BIT_W'(DATA_W - 1);
  localparam logic [CNT_W-1:0] DEPTH_V   = CNT_W'(DEPTH);

`ifdef SPART_PARITY_EN
  typedef enum logic [2:0] {IDLE = 3'd0, START = 3'd1, DATA = 3'd2, PARITY = 3'd3, STOP = 3'd4} state_t;
`else
  typedef enum logic [2:0] {IDLE = 3'd0, START = 3'd1, DATA = 3'd2, STOP = 3'd4} state_t;
`endif

  // Even parity: the transmitted bit makes the total count of ones even.
  function automatic logic even_par(input logic [DATA_W-1:0] d);
    return ^d;
  endfunction

  logic              rx_meta_r, rx_sync_r, rx_prev_r;
  logic              fall_s;
  logic [DIV_W-1:0]  div_r, baud_cnt_r;
  logic              tick_s;
  state_t            state_r, state_nxt_s;
  logic [3:0]        cnt_r, cnt_nxt_s;
  logic [BIT_W-1:0]  bitn_r, bitn_nxt_s;
  logic [DATA_W-1:0] shift_r, shift_nxt_s;
  logic              par_bad_r, par_bad_nxt_s;
  logic              push_req_s, ferr_set_s, perr_set_s;
  logic              push_s, pop_s, ovr_set_s;
  logic [DATA_W-1:0] mem_r [DEPTH];
  logic [PTR_W-1:0]  wr_ptr_r, rd_ptr_r, rd_ptr_nxt_s;
  logic [CNT_W-1:0]  count_r, count_nxt_s;
  logic [DATA_W-1:0] head_nxt_s;
  logic [DATA_W-1:0] rd_data_r;
  logic              rx_valid_r, fifo_full_r, busy_r;
  logic              overrun_r, frame_err_r, par_err_r;

  // Two-stage synchronizer plus previous-sample flop; idle-high reset avoids a false edge.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rx_meta_r <= 1'b1;
      rx_sync_r <= 1'b1;
      rx_prev_r <= 1'b1;
    end else begin
      rx_meta_r <= rxd;
      rx_sync_r <= rx_meta_r;
      rx_prev_r <= rx_sync_r;
    end
  end

  assign fall_s = rx_prev_r & ~rx_sync_r;
  assign tick_s = (baud_cnt_r == {DIV_W{1'b0}});

  // Baud divisor register and oversample tick down-counter.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      div_r      <= DIV_RST_V;
      baud_cnt_r <= DIV_RST_V;
    end else if (div_wr) begin
      div_r      <= div_din;
      baud_cnt_r <= div_din;
    end else if (tick_s) begin
      baud_cnt_r <= div_r;
    end else begin
      baud_cnt_r <= baud_cnt_r - {{(DIV_W-1){1'b0}}, 1'b1};
    end
  end

  // Receiver next-state: mid-bit sampling at tick 7 of start, then every 16th tick.
  always_comb begin
    state_nxt_s   = state_r;
    cnt_nxt_s     = cnt_r;
    bitn_nxt_s    = bitn_r;
    shift_nxt_s   = shift_r;
    par_bad_nxt_s = par_bad_r;
    push_req_s    = 1'b0;
    ferr_set_s    = 1'b0;
    perr_set_s    = 1'b0;
    if (div_wr) begin
      state_nxt_s = IDLE;
      cnt_nxt_s   = 4'd0;
    end else begin
      case (state_r)
        IDLE: begin
          if (fall_s) begin
            state_nxt_s   = START;
            cnt_nxt_s     = 4'd0;
            par_bad_nxt_s = 1'b0;
          end else begin
            state_nxt_s = IDLE;
          end
        end
        START: begin
          if (tick_s && cnt_r == 4'd7) begin
            cnt_nxt_s   = 4'd0;
            bitn_nxt_s  = {BIT_W{1'b0}};
            state_nxt_s = rx_sync_r ? IDLE : DATA;
          end else if (tick_s) begin
            cnt_nxt_s = cnt_r + 4'd1;
          end else begin
            cnt_nxt_s = cnt_r;
          end
        end
        DATA: begin
          if (tick_s && cnt_r == 4'd15) begin
            cnt_nxt_s   = 4'd0;
            shift_nxt_s = {rx_sync_r, shift_r[DATA_W-1:1]};
            if (bitn_r == LAST_BIT) begin
              bitn_nxt_s = {BIT_W{1'b0}};
`ifdef SPART_PARITY_EN
              state_nxt_s = PARITY;
`else
              state_nxt_s = STOP;
`endif
            end else begin
              bitn_nxt_s = bitn_r + {{(BIT_W-1){1'b0}}, 1'b1};
            end
          end else if (tick_s) begin
            cnt_nxt_s = cnt_r + 4'd1;
          end else begin
            cnt_nxt_s = cnt_r;
          end
        end
`ifdef SPART_PARITY_EN
        PARITY: begin
          if (tick_s && cnt_r == 4'd15) begin
            cnt_nxt_s     = 4'd0;
            par_bad_nxt_s = (rx_sync_r != even_par(shift_r));
            perr_set_s    = par_bad_nxt_s;
            state_nxt_s   = STOP;
          end else if (tick_s) begin
            cnt_nxt_s = cnt_r + 4'd1;
          end else begin
            cnt_nxt_s = cnt_r;
          end
        end
`endif
        STOP: begin
          if (tick_s && cnt_r == 4'd15) begin
            cnt_nxt_s   = 4'd0;
            state_nxt_s = IDLE;
            push_req_s  = rx_sync_r & ~par_bad_r;
            ferr_set_s  = ~rx_sync_r;
          end else if (tick_s) begin
            cnt_nxt_s = cnt_r + 4'd1;
          end else begin
            cnt_nxt_s = cnt_r;
          end
        end
        default: begin
          state_nxt_s = IDLE;
          cnt_nxt_s   = 4'd0;
        end
      endcase
    end
  end

  // Receiver state registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_r   <= IDLE;
      cnt_r     <= 4'd0;
      bitn_r    <= {BIT_W{1'b0}};
      shift_r   <= {DATA_W{1'b0}};
      par_bad_r <= 1'b0;
    end else begin
      state_r   <= state_nxt_s;
      cnt_r     <= cnt_nxt_s;
      bitn_r    <= bitn_nxt_s;
      shift_r   <= shift_nxt_s;
      par_bad_r <= par_bad_nxt_s;
    end
  end

  // A simultaneous pop frees the slot, so a full FIFO still accepts the frame.
  assign pop_s     = rd_en && (count_r != {CNT_W{1'b0}});
  assign push_s    = push_req_s && ((count_r != DEPTH_V) || pop_s);
  assign ovr_set_s = push_req_s && (count_r == DEPTH_V) && !pop_s;

  // FIFO occupancy and the next head value for the registered read port.
  always_comb begin
    rd_ptr_nxt_s = pop_s ? rd_ptr_r + {{(PTR_W-1){1'b0}}, 1'b1} : rd_ptr_r;
    case ({push_s, pop_s})
      2'b10:   count_nxt_s = count_r + {{(CNT_W-1){1'b0}}, 1'b1};
      2'b01:   count_nxt_s = count_r - {{(CNT_W-1){1'b0}}, 1'b1};
      default: count_nxt_s = count_r;
    endcase
    if (count_nxt_s == {CNT_W{1'b0}}) begin
      head_nxt_s = {DATA_W{1'b0}};
    end else if (push_s && (count_r == {CNT_W{1'b0}} ||
                            (pop_s && count_r == {{(CNT_W-1){1'b0}}, 1'b1}))) begin
      head_nxt_s = shift_r;
    end else begin
      head_nxt_s = mem_r[rd_ptr_nxt_s];
    end
  end

  // FIFO storage, pointers and registered status outputs.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < DEPTH; i++) mem_r[i] <= {DATA_W{1'b0}};
      wr_ptr_r    <= {PTR_W{1'b0}};
      rd_ptr_r    <= {PTR_W{1'b0}};
      count_r     <= {CNT_W{1'b0}};
      rd_data_r   <= {DATA_W{1'b0}};
      rx_valid_r  <= 1'b0;
      fifo_full_r <= 1'b0;
      busy_r      <= 1'b0;
    end else begin
      if (push_s) begin
        mem_r[wr_ptr_r] <= shift_r;
        wr_ptr_r        <= wr_ptr_r + {{(PTR_W-1){1'b0}}, 1'b1};
      end else begin
        wr_ptr_r <= wr_ptr_r;
      end
      rd_ptr_r    <= rd_ptr_nxt_s;
      count_r     <= count_nxt_s;
      rd_data_r   <= head_nxt_s;
      rx_valid_r  <= (count_nxt_s != {CNT_W{1'b0}});
      fifo_full_r <= (count_nxt_s == DEPTH_V);
      busy_r      <= (state_nxt_s != IDLE);
    end
  end

  // Sticky error flags; a new error in the clearing cycle keeps the flag set.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      overrun_r   <= 1'b0;
      frame_err_r <= 1'b0;
      par_err_r   <= 1'b0;
    end else begin
      overrun_r   <= ovr_set_s  ? 1'b1 : (err_clr ? 1'b0 : overrun_r);
      frame_err_r <= ferr_set_s ? 1'b1 : (err_clr ? 1'b0 : frame_err_r);
      par_err_r   <= perr_set_s ? 1'b1 : (err_clr ? 1'b0 : par_err_r);
    end
  end

  assign rd_data   = rd_data_r;
  assign rx_valid  = rx_valid_r;
  assign fifo_full = fifo_full_r;
  assign busy      = busy_r;
  assign overrun   = overrun_r;
  assign frame_err = frame_err_r;
`ifdef SPART_PARITY_EN
  assign par_err   = par_err_r;
`else
  assign par_err   = 1'b0;
`endif

endmodule
